// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS opcode/funct constants, flag and exception bit indices, stage FSM type.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  // alu_flags = {zero, negative, overflow}
  localparam int FLAG_ZERO = 2;
  localparam int FLAG_NEG  = 1;
  localparam int FLAG_OVF  = 0;

  // exc = {misalign, overflow-or-bus}
  localparam int EXC_MISALIGN = 1;
  localparam int EXC_OVF_BUS  = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RETIRE = 2'd2
  } mem_state_t;

  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

  // Only the signed arithmetic forms suppress write-back on overflow.
  function automatic logic traps_on_overflow(input logic [31:0] ins);
    return ((ins[31:26] == OP_RTYPE) && ((ins[5:0] == FN_ADD) || (ins[5:0] == FN_SUB)))
           || (ins[31:26] == OP_ADDI);
  endfunction

endpackage

// File: rtl/wb_dest_decode.sv
// rtl/wb_dest_decode.sv - destination register and raw write-enable decode for the memory stage.
module wb_dest_decode
  import mips_pkg::*;
(
  input  logic [31:0] instruction,
  output logic [4:0]  wb_reg,
  output logic        wb_en_raw
);

  logic unused_fields;
  assign unused_fields = ^{instruction[25:21], instruction[10:0]};

  always_comb begin
    wb_reg    = instruction[20:16];
    wb_en_raw = 1'b0;
    case (instruction[31:26])
      OP_RTYPE: begin
        wb_reg    = instruction[15:11];
        wb_en_raw = 1'b1;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LW: begin
        wb_en_raw = 1'b1;
      end
      default: begin
        wb_en_raw = 1'b0;
      end
    endcase
    // $0 is hardwired; never request a write to it.
    if (wb_reg == 5'd0) begin
      wb_en_raw = 1'b0;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MIPS memory-access stage: IDLE/ACCESS/RETIRE with data-memory handshake.
// Optional MEM_TIMEOUT_EN: bus-error after TIMEOUT_CYCLES ACCESS cycles without dmem_ack.
module mem_access_stage
  import mips_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instruction,
  input  logic [31:0] alu_result,
  input  logic [2:0]  alu_flags,
  input  logic [31:0] store_data,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic        wb_en,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data,
  output logic [1:0]  exc
);

  mem_state_t  state, state_n;
  logic [31:0] instr_q;
  logic [31:0] addr_q;
  logic [2:0]  flags_q;
  logic [31:0] sdata_q;
  logic [31:0] rdata_q;
  logic        timeout_q;
  logic        timeout_hit;

  logic [4:0]  dec_reg;
  logic        dec_en_raw;
  logic        is_lw_q;
  logic        is_sw_q;
  logic        misalign_q;
  logic        ovf_q;
  logic        in_access;
  logic        in_retire;

  logic unused_flags;
  assign unused_flags = ^{flags_q[FLAG_ZERO], flags_q[FLAG_NEG]};

  wb_dest_decode u_dest (
    .instruction (instr_q),
    .wb_reg      (dec_reg),
    .wb_en_raw   (dec_en_raw)
  );

  assign is_lw_q    = (instr_q[31:26] == OP_LW);
  assign is_sw_q    = (instr_q[31:26] == OP_SW);
  assign misalign_q = is_mem_op(instr_q[31:26]) && (addr_q[1:0] != 2'b00);
  assign ovf_q      = traps_on_overflow(instr_q) && flags_q[FLAG_OVF];
  assign in_access  = (state == ST_ACCESS);
  assign in_retire  = (state == ST_RETIRE);

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] access_cnt;

  // Counts ACCESS cycles already spent; zero in the first ACCESS cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      access_cnt <= '0;
    end else if (!in_access) begin
      access_cnt <= '0;
    end else begin
      access_cnt <= access_cnt + 1'b1;
    end
  end

  assign timeout_hit = in_access && !dmem_ack && (access_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      instr_q   <= '0;
      addr_q    <= '0;
      flags_q   <= '0;
      sdata_q   <= '0;
      rdata_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state <= state_n;
      if (state == ST_IDLE && in_valid) begin
        instr_q   <= instruction;
        addr_q    <= alu_result;
        flags_q   <= alu_flags;
        sdata_q   <= store_data;
        rdata_q   <= '0;
        timeout_q <= 1'b0;
      end
      if (in_access && dmem_ack && is_lw_q) begin
        rdata_q <= dmem_rdata;
      end
      if (timeout_hit) begin
        timeout_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          if (is_mem_op(instruction[31:26]) && (alu_result[1:0] == 2'b00)) begin
            state_n = ST_ACCESS;
          end else begin
            state_n = ST_RETIRE;
          end
        end
      end
      ST_ACCESS: begin
        if (dmem_ack || timeout_hit) begin
          state_n = ST_RETIRE;
        end
      end
      ST_RETIRE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Bus outputs are gated by state so an async reset clears them at once.
  always_comb begin
    in_ready   = (state == ST_IDLE);
    dmem_req   = in_access;
    dmem_we    = in_access && is_sw_q;
    dmem_addr  = in_access ? addr_q : 32'd0;
    dmem_wdata = in_access ? sdata_q : 32'd0;

    wb_valid = in_retire;
    wb_en    = in_retire && dec_en_raw && !ovf_q && !misalign_q && !timeout_q;
    wb_reg   = in_retire ? dec_reg : 5'd0;
    wb_data  = 32'd0;
    if (in_retire) begin
      wb_data = is_lw_q ? rdata_q : addr_q;
    end
    exc = 2'b00;
    if (in_retire) begin
      exc[EXC_MISALIGN] = misalign_q;
      exc[EXC_OVF_BUS]  = ovf_q || timeout_q;
    end
  end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16: cycles to wait for dmem_ack before a bus error (used only with MEM_TIMEOUT_EN).
REQ-002 SHALL have one clock and an asynchronous, active-high reset; the ports below SHALL appear in this order.
REQ-003 clk  in  1  sole clock; all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-high.
REQ-005 in_valid  in  1  upstream ALU stage presents an instruction.
REQ-006 in_ready  out  1  stage can accept an instruction this cycle.
REQ-007 instruction  in  32  MIPS instruction word paired with the ALU output.
REQ-008 alu_result  in  32  ALU result; the byte address for lw/sw.
REQ-009 alu_flags  in  3  {zero, negative, overflow} from the ALU.
REQ-010 store_data  in  32  rt register value for sw.
REQ-011 dmem_req  out  1  data-memory request.
REQ-012 dmem_we  out  1  1 = write (sw), 0 = read (lw).
REQ-013 dmem_addr  out  32  byte address.
REQ-014 dmem_wdata  out  32  write data.
REQ-015 dmem_ack  in  1  memory completes the request.
REQ-016 dmem_rdata  in  32  read data, valid while dmem_ack is high.
REQ-017 wb_valid  out  1  one-cycle pulse: instruction retired.
REQ-018 wb_en  out  1  register write required; qualified by wb_valid.
REQ-019 wb_reg  out  5  destination register.
REQ-020 wb_data  out  32  write-back data.
REQ-021 exc  out  2  {misalign, overflow-or-bus}; qualified by wb_valid.

Function
REQ-022 SHALL use an FSM with states IDLE, ACCESS and RETIRE; in_ready SHALL be 1 only in IDLE.
REQ-023 IDLE: when in_valid is high, SHALL capture instruction, alu_result, alu_flags and store_data; lw/sw (opcode 100011/101011) with an aligned address go to ACCESS; everything else goes to RETIRE.
REQ-024 ACCESS: dmem_req SHALL be 1 with dmem_addr, dmem_we and dmem_wdata stable from the captured values until dmem_ack is sampled high; the FSM then goes to RETIRE, and lw latches dmem_rdata.
REQ-025 dmem_ack in the first ACCESS cycle SHALL be legal (minimum memory latency 1); dmem_ack outside ACCESS SHALL be ignored.
REQ-026 RETIRE: wb_valid SHALL be 1 for exactly one cycle, then the FSM returns to IDLE; latency is accept-to-wb_valid = 1 cycle for non-memory instructions and (cycles to ack) + 1 for lw/sw.
REQ-027 Destination: R-type (opcode 000000) uses rd = [15:11]; addi, addiu, slti, sltiu, andi, ori, xori and lw use rt = [20:16].
REQ-028 sw, beq and bne SHALL have wb_en = 0.
REQ-029 Any write to register 0 SHALL have wb_en = 0.
REQ-030 wb_data SHALL be the latched dmem_rdata for lw and the captured alu_result otherwise.
REQ-031 For add, sub and addi with captured overflow flag = 1: wb_en = 0 and exc[0] = 1.
REQ-032 For lw/sw with address[1:0] != 0: no dmem_req, go straight to RETIRE, wb_en = 0, exc[1] = 1.
REQ-033 Reset asserted mid-ACCESS SHALL drop dmem_req immediately (asynchronous) with no retirement.

Reset
REQ-034 During and after reset: FSM = IDLE, in_ready = 1, and dmem_req, dmem_we, wb_valid, wb_en, exc, wb_reg, wb_data, dmem_addr and dmem_wdata all = 0.

Configuration
REQ-035 MEM_TIMEOUT_EN defined: an ACCESS cycle counter SHALL, when TIMEOUT_CYCLES cycles elapse without dmem_ack, drop dmem_req, go to RETIRE with wb_en = 0 and exc[0] = 1; the counter clears on entering ACCESS.
REQ-036 MEM_TIMEOUT_EN undefined: no counter SHALL exist, and ACCESS waits for dmem_ack indefinitely.

Structure
REQ-037 Opcode/funct constants, the FSM state typedef and exc bit indices SHALL live in shared package mips_pkg, also used by alu.
REQ-038 Destination/write-enable decode SHALL be the combinational sub-module wb_dest_decode (instruction -> wb_reg, wb_en_raw).

Verification
REQ-039 add $3,$1,$2 with alu_result = 7 and flags = 000 -> wb_valid 1 cycle after accept, wb_en = 1, wb_reg = 3, wb_data = 7.
REQ-040 lw $5,0($4) with alu_result = 0x100 and ack after 3 cycles with rdata = 0xDEADBEEF -> dmem_req held 3 cycles with addr = 0x100 and we = 0; wb_reg = 5, wb_data = 0xDEADBEEF.
REQ-041 sw with alu_result = 0x102 -> no dmem_req, exc = 10, wb_en = 0.
REQ-042 addi $2,$1,1 with flags = 001 -> exc = 01, wb_en = 0; addi targeting $0 -> wb_en = 0.
REQ-043 sw at 0x200, no ack, MEM_TIMEOUT_EN defined -> dmem_req drops after 16 cycles, exc = 01; reset asserted mid-ACCESS -> dmem_req = 0 immediately and in_ready = 1.
